aes128_key_expander: RTL and testbench

Iterative AES-128 key-schedule engine that sits directly upstream of the AES encrypt/decrypt datapath. It accepts a 128-bit cipher key over a valid/ready handshake and computes one round key per clock into an 11-entry round-key store. It then serves any round key through an indexed read port. It replaces the unrolled combinational expansion so that the round datapath can be iterated without re-deriving keys.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes128_key_expander_if.sv | 35 +++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes128_key_expander.sv | 146 ++++++++++++++
 tb/tb_aes128_key_expander.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key-schedule engine and the round datapath:
//   AES_NR128 / AES_NK128 : round count and key length in 32-bit words
//   AES_RCON              : round-constant table (first byte of each Rcon word)
//   ks_state_e            : key-schedule FSM states (IDLE, EXPAND)
//   xtime / gf_mul        : GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_NR128 = 10;
   localparam int AES_NK128 = 4;

   localparam logic [7:0] AES_RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } ks_state_e;

   // Multiply by x in GF(2^8).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product, shift-and-add over the bits of b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

endpackage

// File: rtl/aes128_key_expander_if.sv
// ---------------------------------------------------------------------------
// aes128_key_expander_if
// Key-load handshake and round-key read port of the AES-128 key expander.
//   key_valid : source -> engine, key is valid this cycle
//   key_ready : engine -> source, engine can accept a key
//   key       : 128-bit cipher key, byte 0 in key[127:120]
//   rk_idx    : round-key index, 0..10
//   rk        : selected round key
// master = key source / round datapath, slave = key expander.
// ---------------------------------------------------------------------------
interface aes128_key_expander_if;

   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic [3:0]   rk_idx;
   logic [127:0] rk;

   modport master (
      output key_valid,
      output key,
      output rk_idx,
      input  key_ready,
      input  rk
   );

   modport slave (
      input  key_valid,
      input  key,
      input  rk_idx,
      output key_ready,
      output rk
   );

endinterface

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
//   in_i  : input byte
//   out_o : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   logic [7:0] pw;
   logic [7:0] inv;

   // inverse = a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 naturally
   always_comb begin
      pw  = in_i;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
      out_o = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
   end

endmodule

// File: rtl/aes128_key_expander.sv
// ---------------------------------------------------------------------------
// aes128_key_expander
// Iterative AES-128 key schedule. A key accepted over the valid/ready
// handshake is stored as round key 0; one further round key is derived per
// clock into an 11-entry store, after which any round key can be read by
// index.
// Parameters:
//   OUT_REG : 1 = registered rk (one cycle after rk_idx), 0 = combinational
//   NR      : number of rounds, must be 10
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   kx          : key handshake and read port (slave side)
//   busy        : expansion in progress
//   done        : one-cycle pulse once all 11 round keys are stored
//   keys_valid  : store holds a complete schedule
// Build option:
//   AES_KEYEXP_REVERSE_EN : read port returns store[10-rk_idx] (decryption)
// ---------------------------------------------------------------------------
module aes128_key_expander
   import aes_pkg::*;
#(
   parameter int OUT_REG = 1,
   parameter int NR      = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   aes128_key_expander_if.slave  kx,
   output logic                  busy,
   output logic                  done,
   output logic                  keys_valid
);

   localparam logic [3:0] LAST_R = 4'(AES_NR128);

   if (NR != AES_NR128) begin : g_nr_check
      $error("aes128_key_expander: only NR=10 is supported");
   end

   ks_state_e    state_q;
   logic [3:0]   r_q;
   logic [7:0]   rcon_q;
   logic         done_q;
   logic         kv_q;
   logic [127:0] store_q [0:10];

   logic [3:0]   prev_idx;
   logic [127:0] prev_rk;
   logic [31:0]  rot_w3;
   logic [31:0]  sub_w;
   logic [31:0]  word_acc;
   logic [127:0] next_rk;

   // Previous round key; r_q is 1..10 whenever the result is used.
   assign prev_idx = r_q - 4'd1;
   assign prev_rk  = (prev_idx <= LAST_R) ? store_q[prev_idx] : '0;

   // SubWord(RotWord(w3)) of the previous round key
   assign rot_w3 = {prev_rk[23:0], prev_rk[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (rot_w3[8*b +: 8]),
         .out_o (sub_w[8*b +: 8])
      );
   end

   // Each new word is the running XOR: w0'=w0^t, w1'=w1^w0', ...
   always_comb begin
      next_rk  = '0;
      word_acc = sub_w ^ {rcon_q, 24'h0};
      for (int i = 0; i < AES_NK128; i++) begin
         word_acc = word_acc ^ prev_rk[127-32*i -: 32];
         next_rk[127-32*i -: 32] = word_acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         r_q     <= 4'd0;
         rcon_q  <= 8'h00;
         done_q  <= 1'b0;
         kv_q    <= 1'b0;
         for (int k = 0; k <= AES_NR128; k++) begin
            store_q[k] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (kx.key_valid) begin
                  store_q[0] <= kx.key;
                  r_q        <= 4'd1;
                  rcon_q     <= AES_RCON[0];
                  kv_q       <= 1'b0;
                  state_q    <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               store_q[r_q] <= next_rk;
               r_q          <= r_q + 4'd1;
               rcon_q       <= xtime(rcon_q);
               if (r_q == LAST_R) begin
                  done_q  <= 1'b1;
                  kv_q    <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign kx.key_ready = (state_q == ST_IDLE);
   assign busy         = (state_q == ST_EXPAND);
   assign done         = done_q;
   assign keys_valid   = kv_q;

   // Read port: index mapping, range check and validity gating
   logic         in_range;
   logic [3:0]   phys_idx;
   logic [3:0]   sel_idx;
   logic [127:0] rk_d;

`ifdef AES_KEYEXP_REVERSE_EN
   assign phys_idx = LAST_R - kx.rk_idx;
`else
   assign phys_idx = kx.rk_idx;
`endif

   assign in_range = (kx.rk_idx <= LAST_R);
   assign sel_idx  = in_range ? phys_idx : 4'd0;
   assign rk_d     = (kv_q && in_range) ? store_q[sel_idx] : '0;

   if (OUT_REG != 0) begin : g_rk_reg
      logic [127:0] rk_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) rk_q <= '0;
         else        rk_q <= rk_d;
      end
      assign kx.rk = rk_q;
   end else begin : g_rk_comb
      assign kx.rk = rk_d;
   end

endmodule

// File: tb/tb_aes128_key_expander.sv
module tb_aes128_key_expander;

   localparam int OUT_REG = 1;
   localparam int LAT     = OUT_REG;
`ifdef AES_KEYEXP_REVERSE_EN
   localparam bit REV = 1'b1;
`else
   localparam bit REV = 1'b0;
`endif

   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   logic clk;
   logic rst_n;
   logic busy, done, keys_valid;

   aes128_key_expander_if kx ();

   aes128_key_expander #(.OUT_REG(OUT_REG), .NR(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .kx         (kx),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           due;
      logic [127:0] val;
      int           idx;
   } rd_t;

   int   exp_done[$];
   rd_t  exp_rd[$];
   int   nchk = 0;
   int   nerr = 0;
   int   n_done = 0;
   int   exp_n_done = 0;
   int   last_h = 0;

   logic [7:0]   sbox_t [0:255];
   logic [127:0] model_key = '0;
   bit           model_valid = 1'b0;
   logic [127:0] pend_key = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   // ---------------- reference model (FIPS-197 word recurrence) ----------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, c, s;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_t[x] = s;
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
      logic [31:0] w [0:43];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0)
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                ^ {RCON[i/4-1], 24'h0};
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic int lidx(input int r);
      return REV ? 10 - r : r;
   endfunction

   function automatic logic [127:0] exp_val(input int idx);
      if (!model_valid || idx > 10) return '0;
      return round_key(model_key, REV ? 10 - idx : idx);
   endfunction

   // ---------------- stimulus tasks ---------------------------------------
   task automatic rd(input int idx, input bit use_c, input logic [127:0] cval);
      rd_t e;
      @(posedge clk); #1;
      if (LAT != 0) begin
         e.due = cyc; e.val = exp_val(int'(kx.rk_idx)); e.idx = int'(kx.rk_idx);
         exp_rd.push_back(e);
      end
      kx.rk_idx = 4'(idx);
      e.due = cyc + LAT; e.val = use_c ? cval : exp_val(idx); e.idx = idx;
      exp_rd.push_back(e);
   endtask

   task automatic sweep();
      for (int i = 0; i < 16; i++) rd(i, 1'b0, '0);
      for (int i = 0; i < 4; i++) rd($urandom_range(0, 15), 1'b0, '0);
   endtask

   task automatic send_key(input logic [127:0] k, input bit keep);
      bit ok;
      ok = 1'b0;
      kx.key = k;
      kx.key_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (kx.key_ready) begin ok = 1'b1; break; end
      end
      chk("key_accept", 128'(ok), 128'd1);
      if (!ok) begin kx.key_valid = 1'b0; return; end
      @(posedge clk); #1;
      last_h = cyc;
      exp_done.push_back(cyc + 10);
      exp_n_done++;
      model_valid = 1'b0;
      pend_key = k;
      if (!keep) kx.key_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (exp_done.size() == 0) break;
      end
      chk("done_seen", 128'(exp_done.size()), 128'd0);
      exp_done.delete();
      model_key = pend_key;
      model_valid = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- monitor ----------------------------------------------
   initial begin
      rd_t e;
      int  d;
      forever begin
         @(negedge clk);
         if (done) begin
            n_done++;
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 128'd1, 128'd0);
            end else begin
               d = exp_done.pop_front();
               chk("done_cycle", 128'(cyc), 128'(d));
               chk("keys_valid_at_done", 128'(keys_valid), 128'd1);
               chk("key_ready_at_done", 128'(kx.key_ready), 128'd1);
            end
         end
         while (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
            e = exp_rd.pop_front();
            if (e.due != cyc) chk("rd_missed", 128'(cyc), 128'(e.due));
            else chk($sformatf("rk[%0d]@%0d", e.idx, e.due), kx.rk, e.val);
         end
      end
   end

   // ---------------- main sequence ----------------------------------------
   initial begin
      logic [127:0] ka, k1, k2;
      rd_t e;
      int  h1;
      build_sbox();
      rst_n = 1'b0;
      kx.key_valid = 1'b0;
      kx.key = '0;
      kx.rk_idx = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_key_ready", 128'(kx.key_ready), 128'd1);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_keys_valid", 128'(keys_valid), 128'd0);
      chk("rst_rk", kx.rk, '0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // no schedule yet: every index reads zero
      rd(0, 1'b1, '0); rd(11, 1'b1, '0); rd(15, 1'b1, '0);

      // FIPS-197 key
      ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      send_key(ka, 1'b0);
      wait_done();
      rd(lidx(1), 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(lidx(10), 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd(lidx(0), 1'b1, ka);
      sweep();

      send_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
      wait_done();
      rd(lidx(10), 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      send_key('0, 1'b0);
      wait_done();
      rd(lidx(1), 1'b1, 128'h62636363626363636263636362636363);
      sweep();

      for (int n = 0; n < 4; n++) begin
         send_key(rnd128(), 1'b0);
         wait_done();
         sweep();
      end

      // back-to-back: second key held during EXPAND
      rd(10, 1'b0, '0);
      k1 = rnd128();
      k2 = rnd128();
      send_key(k1, 1'b1);
      h1 = last_h;
      e.due = h1 + 10 + LAT;
      e.val = round_key(k1, REV ? 0 : 10);
      e.idx = 10;
      exp_rd.push_back(e);
      send_key(k2, 1'b0);
      chk("b2b_accept_cycle", 128'(last_h), 128'(h1 + 11));
      wait_done();
      sweep();

      // reset in the middle of an expansion
      send_key(rnd128(), 1'b0);
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_key_ready", 128'(kx.key_ready), 128'd1);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_done", 128'(done), 128'd0);
      chk("abort_keys_valid", 128'(keys_valid), 128'd0);
      chk("abort_rk", kx.rk, '0);
      exp_done.delete();
      exp_n_done--;
      model_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      sweep();

      send_key(rnd128(), 1'b0);
      wait_done();
      sweep();

      repeat (5) @(posedge clk);
      #1;
      chk("pending_done", 128'(exp_done.size()), 128'd0);
      chk("pending_reads", 128'(exp_rd.size()), 128'd0);
      chk("done_count", 128'(n_done), 128'(exp_n_done));
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
